closest_hit_select: RTL and testbench

CLOSEST_HIT_SELECT -- requirements
Module: closest_hit_select

---
 rtl/closest_hit_select.sv | 137 +++++++++++++
 tb/tb_closest_hit_select.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/closest_hit_select.sv
// closest_hit_select: scans a stream of ray/triangle test results and keeps
// the nearest qualifying hit (flagged, beyond EPS, strictly closer than best).
// The captured ray plus the winning hit are presented until downstream accepts.
module closest_hit_select #(
  parameter logic [31:0] DIST_MAX = 32'h7FFF_FFFF,
  parameter logic [31:0] EPS      = 32'h0000_0001,
  parameter int unsigned IDX_W    = 16,
  parameter int unsigned RAY_W    = 192,
  parameter int unsigned TRIG_W   = 288
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RAY_W-1:0]  ray_in,
  input  logic              hit_valid,
  output logic              hit_ready,
  input  logic              hit_flag,
  input  logic [31:0]       hit_dist,
  input  logic [TRIG_W-1:0] hit_trig,
  input  logic [31:0]       hit_of,
  input  logic              hit_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_found,
  output logic [RAY_W-1:0]  res_ray,
  output logic [TRIG_W-1:0] res_trig,
  output logic [31:0]       res_dist,
  output logic [31:0]       res_of,
  output logic [IDX_W-1:0]  res_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [31:0] EPS_S = EPS;

  logic [1:0]        state_q, state_d;
  logic [RAY_W-1:0]  ray_q, ray_d;
  logic [31:0]       best_q, best_d;
  logic [TRIG_W-1:0] trig_q, trig_d;
  logic [31:0]       of_q, of_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              found_q, found_d;

  logic signed [31:0] dist_s;
  logic signed [31:0] best_s;
  logic               beat_acc;
  logic               qualify;

  assign dist_s   = hit_dist;
  assign best_s   = best_q;
  assign beat_acc = hit_valid && (state_q == S_SCAN);
  // Strict less-than keeps the earlier triangle on equal distances.
  assign qualify  = hit_flag && (dist_s > EPS_S) && (dist_s < best_s);

  // Next-state and result-register update logic.
  always_comb begin
    state_d = state_q;
    ray_d   = ray_q;
    best_d  = best_q;
    trig_d  = trig_q;
    of_d    = of_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          ray_d   = ray_in;
          best_d  = DIST_MAX;
          trig_d  = '0;
          of_d    = '0;
          idx_d   = '0;
          cnt_d   = '0;
          found_d = 1'b0;
        end
      end
      S_SCAN: begin
        if (beat_acc) begin
          if (qualify) begin
            best_d  = hit_dist;
            trig_d  = hit_trig;
            of_d    = hit_of;
            idx_d   = cnt_q;
            found_d = 1'b1;
          end
          cnt_d = cnt_q + IDX_W'(1);
          if (hit_last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; async reset abandons any search in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ray_q   <= '0;
      best_q  <= DIST_MAX;
      trig_q  <= '0;
      of_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ray_q   <= ray_d;
      best_q  <= best_d;
      trig_q  <= trig_d;
      of_q    <= of_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
    end
  end

  assign hit_ready = (state_q == S_SCAN);
  assign res_valid = (state_q == S_DONE);
  assign res_found = found_q;
  assign res_ray   = ray_q;
  assign res_trig  = trig_q;
  assign res_dist  = best_q;
  assign res_of    = of_q;
  assign res_idx   = idx_q;

endmodule

// File: tb/tb_closest_hit_select.sv
// Directed bench for closest_hit_select: hand-computed expectations checked
// with immediate assertions; inputs driven and outputs sampled on negedge.
module tb_closest_hit_select;

  localparam int unsigned IDX_W  = 16;
  localparam int unsigned RAY_W  = 192;
  localparam int unsigned TRIG_W = 288;
  localparam logic [31:0] DMAX   = 32'h7FFF_FFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [RAY_W-1:0]  ray_in;
  logic              hit_valid;
  logic              hit_ready;
  logic              hit_flag;
  logic [31:0]       hit_dist;
  logic [TRIG_W-1:0] hit_trig;
  logic [31:0]       hit_of;
  logic              hit_last;
  logic              res_valid;
  logic              res_ready;
  logic              res_found;
  logic [RAY_W-1:0]  res_ray;
  logic [TRIG_W-1:0] res_trig;
  logic [31:0]       res_dist;
  logic [31:0]       res_of;
  logic [IDX_W-1:0]  res_idx;

  int total = 0;
  int bad   = 0;

  closest_hit_select #(
    .DIST_MAX(DMAX),
    .EPS     (32'h0000_0001),
    .IDX_W   (IDX_W),
    .RAY_W   (RAY_W),
    .TRIG_W  (TRIG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ray_in   (ray_in),
    .hit_valid(hit_valid),
    .hit_ready(hit_ready),
    .hit_flag (hit_flag),
    .hit_dist (hit_dist),
    .hit_trig (hit_trig),
    .hit_of   (hit_of),
    .hit_last (hit_last),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_found(res_found),
    .res_ray  (res_ray),
    .res_trig (res_trig),
    .res_dist (res_dist),
    .res_of   (res_of),
    .res_idx  (res_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [RAY_W-1:0] r);
    start  = 1'b1;
    ray_in = r;
    @(negedge clk);
    start  = 1'b0;
    ray_in = '1;  // must not be captured after the start edge
  endtask

  // One beat presented for exactly one rising edge.
  task automatic beat(input logic f, input logic [31:0] d, input int k, input logic last);
    hit_valid = 1'b1;
    hit_flag  = f;
    hit_dist  = d;
    hit_trig  = TRIG_W'(100 + k);
    hit_of    = 32'(200 + k);
    hit_last  = last;
    @(negedge clk);
    hit_valid = 1'b0;
    hit_flag  = 1'b0;
    hit_last  = 1'b0;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] dists [10];
    logic [TRIG_W-1:0] snap_trig;
    logic [31:0]       snap_dist;
    logic [IDX_W-1:0]  snap_idx;

    rst_n = 1'b0; start = 1'b0; ray_in = '0; hit_valid = 1'b0; hit_flag = 1'b0;
    hit_dist = '0; hit_trig = '0; hit_of = '0; hit_last = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ready", hit_ready, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_found", res_found, 0);
    chk("rst_dist",  res_dist, DMAX);
    chk("rst_idx",   res_idx, 0);
    chk("rst_trig",  res_trig, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", hit_ready, 0);

    // Minimum 2.0 at index 1; later equal 2.0 at index 3 must not replace it
    do_start(RAY_W'(192'hABCD));
    chk("t1_scan_ready", hit_ready, 1);
    beat(1'b1, 32'h0005_0000, 0, 1'b0);
    beat(1'b1, 32'h0002_0000, 1, 1'b0);
    beat(1'b1, 32'h0003_0000, 2, 1'b0);
    hit_valid = 1'b1; hit_flag = 1'b1; hit_dist = 32'h0002_0000;
    hit_trig = TRIG_W'(103); hit_of = 32'd203; hit_last = 1'b1;
    chk("t1_valid_before_last", res_valid, 0);
    @(negedge clk);
    hit_valid = 1'b0; hit_flag = 1'b0; hit_last = 1'b0;
    chk("t1_valid", res_valid, 1);
    chk("t1_ready_done", hit_ready, 0);
    chk("t1_found", res_found, 1);
    chk("t1_dist", res_dist, 32'h0002_0000);
    chk("t1_idx", res_idx, 1);
    chk("t1_trig", res_trig, 101);
    chk("t1_of", res_of, 201);
    chk("t1_ray", res_ray, 192'hABCD);
    release_result();
    chk("t1_idle_valid", res_valid, 0);
    chk("t1_idle_ready", hit_ready, 0);

    // Zero, negative and exactly-EPS distances never qualify
    do_start(RAY_W'(5));
    beat(1'b1, 32'h0000_0000, 0, 1'b0);
    beat(1'b1, 32'hFFFF_0000, 1, 1'b0);
    beat(1'b1, 32'h0000_0001, 2, 1'b1);
    chk("t2_valid", res_valid, 1);
    chk("t2_found", res_found, 0);
    chk("t2_dist", res_dist, DMAX);
    chk("t2_idx", res_idx, 0);
    chk("t2_trig", res_trig, 0);
    chk("t2_of", res_of, 0);
    release_result();

    // Unflagged closer beat ignored
    do_start(RAY_W'(6));
    beat(1'b0, 32'h0001_0000, 0, 1'b0);
    beat(1'b1, 32'h0004_0000, 1, 1'b1);
    chk("t3_valid", res_valid, 1);
    chk("t3_idx", res_idx, 1);
    chk("t3_dist", res_dist, 32'h0004_0000);
    chk("t3_found", res_found, 1);

    // DONE holds under backpressure; start and hit_valid ignored
    snap_trig = res_trig; snap_dist = res_dist; snap_idx = res_idx;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; ray_in = RAY_W'(77);
      hit_valid = 1'b1; hit_flag = 1'b1; hit_dist = 32'h0000_8000;
      hit_trig = TRIG_W'(999); hit_last = 1'b1;
      @(negedge clk);
      chk("t4_valid", res_valid, 1);
      chk("t4_ready", hit_ready, 0);
      chk("t4_dist", res_dist, snap_dist);
      chk("t4_idx", res_idx, snap_idx);
      chk("t4_trig", res_trig, snap_trig);
    end
    start = 1'b0; hit_valid = 1'b0; hit_flag = 1'b0; hit_last = 1'b0;
    chk("t4_ray", res_ray, 6);
    release_result();
    chk("t4_idle_valid", res_valid, 0);
    chk("t4_idle_ready", hit_ready, 0);

    // Reset mid-scan abandons the search
    do_start(RAY_W'(8));
    beat(1'b1, 32'h0001_0000, 0, 1'b0);
    beat(1'b1, 32'h0000_8000, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", hit_ready, 0);
    chk("t5_rst_dist", res_dist, DMAX);
    chk("t5_rst_found", res_found, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle_ready", hit_ready, 0);
    chk("t5_idle_valid", res_valid, 0);
    do_start(RAY_W'(9));
    beat(1'b1, 32'h0007_0000, 0, 1'b1);
    chk("t5_valid", res_valid, 1);
    chk("t5_dist", res_dist, 32'h0007_0000);
    chk("t5_idx", res_idx, 0);
    chk("t5_found", res_found, 1);
    release_result();

    // Ten back-to-back beats; minimum 3.0 first seen at index 6
    dists = '{32'h0009_0000, 32'h0008_0000, 32'h000C_0000, 32'h0006_0000, 32'h0006_0000,
              32'h000F_0000, 32'h0003_0000, 32'h000B_0000, 32'h0003_0000, 32'h0014_0000};
    do_start(RAY_W'(10));
    for (int i = 0; i < 10; i++) begin
      chk("t6_ready", hit_ready, 1);
      beat(1'b1, dists[i], i, (i == 9));
    end
    chk("t6_valid", res_valid, 1);
    chk("t6_dist", res_dist, 32'h0003_0000);
    chk("t6_idx", res_idx, 6);
    chk("t6_of", res_of, 206);
    release_result();
    chk("t6_idle_valid", res_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
